// File: rtl/hm_rx.sv
// hm_rx: captures the CplD TLPs answering the single 1024-DW read (rid 16'h1800, tag 8'h38) and repacks the payload into qwords.
// Latency: a beat that completes a DW pair raises hm_data_we on the following cycle; status pulses are also one cycle after the beat.
// Backpressure: none, trn_rdst_rdy_n is held low after reset and every beat with trn_rsrc_rdy_n low is consumed.
module hm_rx (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        rx_start,
    output logic        rx_end,
    output logic        rx_error,
    output logic        timeout,
    input  logic [63:0] trn_rd,
    input  logic        trn_rrem_n,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rsrc_rdy_n,
    input  logic        trn_rsrc_dsc_n,
    input  logic        trn_rerrfwd_n,
    input  logic [6:0]  trn_rbar_hit_n,
    output logic        trn_rdst_rdy_n,
    output logic        trn_rnp_ok_n,
    output logic [63:0] hm_data,
    output logic        hm_data_we,
    output logic [8:0]  hm_data_addr,
    output logic [15:0] stat_trn_cpt_rx,
    output logic [7:0]  stat_trn_cpt_ign,
    output logic [1:0]  stat_state
);

    localparam logic [15:0] REQ_ID        = 16'h1800;
    localparam logic [7:0]  REQ_TAG       = 8'h38;
    localparam logic [7:0]  CPLD_FMT_TYPE = 8'b010_01010;
    localparam logic [15:0] TMO_LIMIT     = 16'hffff;
    localparam logic [8:0]  LAST_QW       = 9'd511;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_H1   = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [2:0]  cpl_status_q, cpl_status_d;
    logic [10:0] dw_cnt_q, dw_cnt_d;
    logic [31:0] held_q, held_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [63:0] hm_data_q, hm_data_d;
    logic        hm_data_we_q, hm_data_we_d;
    logic [8:0]  hm_data_addr_q, hm_data_addr_d;
    logic        rx_end_q, rx_end_d;
    logic        rx_error_q, rx_error_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cpt_rx_q, cpt_rx_d;
    logic [7:0]  cpt_ign_q, cpt_ign_d;
    logic        rdst_rdy_n_q;

    logic        beat, sof, eof, bad_pkt;
    logic [1:0]  pay_n;
    logic [31:0] pay_a, pay_b;
    logic        unused_bar_hit;

    assign beat    = ~trn_rsrc_rdy_n;
    assign sof     = ~trn_rsof_n;
    assign eof     = ~trn_reof_n;
    assign bad_pkt = ~trn_rsrc_dsc_n | ~trn_rerrfwd_n;

    // BAR hit carries no information for a completion stream.
    assign unused_bar_hit = ^trn_rbar_hit_n;

    assign trn_rdst_rdy_n   = rdst_rdy_n_q;
    assign trn_rnp_ok_n     = 1'b0;
    assign hm_data          = hm_data_q;
    assign hm_data_we       = hm_data_we_q;
    assign hm_data_addr     = hm_data_addr_q;
    assign rx_end           = rx_end_q;
    assign rx_error         = rx_error_q;
    assign timeout          = timeout_q;
    assign stat_trn_cpt_rx  = cpt_rx_q;
    assign stat_trn_cpt_ign = cpt_ign_q;
    assign stat_state       = state_q;

    // Next state: TLP parse, DW pair packing, arming and timeout.
    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        cpl_status_d   = cpl_status_q;
        dw_cnt_d       = dw_cnt_q;
        held_d         = held_q;
        tmo_cnt_d      = tmo_cnt_q;
        hm_data_d      = hm_data_q;
        hm_data_we_d   = 1'b0;
        hm_data_addr_d = hm_data_addr_q;
        rx_end_d       = 1'b0;
        rx_error_d     = 1'b0;
        timeout_d      = 1'b0;
        cpt_rx_d       = cpt_rx_q;
        cpt_ign_d      = cpt_ign_q;
        pay_n          = 2'd0;
        pay_a          = trn_rd[63:32];
        pay_b          = trn_rd[31:0];

        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (sof) begin
                        // DW1 of the header rides in the low half of the SOF beat.
                        cpl_status_d = trn_rd[15:13];
                        if (armed_q && trn_rd[63:56] == CPLD_FMT_TYPE) begin
                            state_d = eof ? ST_IDLE : ST_H1;
                        end else begin
                            if (armed_q) begin
                                cpt_ign_d = cpt_ign_q + 8'd1;
                            end
                            state_d = eof ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_H1: begin
                    if (trn_rd[63:48] != REQ_ID || trn_rd[47:40] != REQ_TAG) begin
                        cpt_ign_d = cpt_ign_q + 8'd1;
                        state_d   = eof ? ST_IDLE : ST_DROP;
                    end else if (cpl_status_q != 3'd0 || bad_pkt) begin
                        rx_error_d = armed_q;
                        state_d    = eof ? ST_IDLE : ST_DROP;
                    end else begin
                        // Low half of the second header beat is the first payload DW.
                        pay_n = 2'd1;
                        pay_a = trn_rd[31:0];
                        if (eof) begin
                            cpt_rx_d = cpt_rx_q + 16'd1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bad_pkt) begin
                        rx_error_d = armed_q;
                        state_d    = eof ? ST_IDLE : ST_DROP;
                    end else begin
                        pay_n = (eof && !trn_rrem_n) ? 2'd1 : 2'd2;
                        if (eof) begin
                            cpt_rx_d = cpt_rx_q + 16'd1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (eof) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Payload DWs stream across CplDs in order; an odd DW waits in held_q for its partner.
        if (armed_q && !dw_cnt_q[10] && pay_n != 2'd0) begin
            dw_cnt_d = dw_cnt_q + {9'd0, pay_n};
            if (dw_cnt_q[0]) begin
                hm_data_we_d   = 1'b1;
                hm_data_d      = {held_q, pay_a};
                hm_data_addr_d = dw_cnt_q[9:1];
                if (pay_n == 2'd2) begin
                    held_d = pay_b;
                end
            end else if (pay_n == 2'd2) begin
                hm_data_we_d   = 1'b1;
                hm_data_d      = {pay_a, pay_b};
                hm_data_addr_d = dw_cnt_q[9:1];
            end else begin
                held_d = pay_a;
            end
            if (hm_data_we_d && dw_cnt_q[9:1] == LAST_QW) begin
                rx_end_d = 1'b1;
            end
        end

        // Idle watchdog: only runs while armed, any accepted beat restarts it.
        if (!armed_q || beat) begin
            tmo_cnt_d = 16'd0;
        end else if (tmo_cnt_q == TMO_LIMIT) begin
            timeout_d = 1'b1;
            tmo_cnt_d = 16'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        if (rx_end_d || rx_error_d || timeout_d) begin
            armed_d = 1'b0;
        end

        // A new request (or re-arm) restarts the stream from qword 0.
        if (rx_start) begin
            armed_d   = 1'b1;
            dw_cnt_d  = 11'd0;
            tmo_cnt_d = 16'd0;
            if (!hm_data_we_d) begin
                hm_data_addr_d = 9'd0;
            end
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            armed_q        <= 1'b0;
            cpl_status_q   <= 3'd0;
            dw_cnt_q       <= 11'd0;
            held_q         <= 32'd0;
            tmo_cnt_q      <= 16'd0;
            hm_data_q      <= 64'd0;
            hm_data_we_q   <= 1'b0;
            hm_data_addr_q <= 9'd0;
            rx_end_q       <= 1'b0;
            rx_error_q     <= 1'b0;
            timeout_q      <= 1'b0;
            cpt_rx_q       <= 16'd0;
            cpt_ign_q      <= 8'd0;
            rdst_rdy_n_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            cpl_status_q   <= cpl_status_d;
            dw_cnt_q       <= dw_cnt_d;
            held_q         <= held_d;
            tmo_cnt_q      <= tmo_cnt_d;
            hm_data_q      <= hm_data_d;
            hm_data_we_q   <= hm_data_we_d;
            hm_data_addr_q <= hm_data_addr_d;
            rx_end_q       <= rx_end_d;
            rx_error_q     <= rx_error_d;
            timeout_q      <= timeout_d;
            cpt_rx_q       <= cpt_rx_d;
            cpt_ign_q      <= cpt_ign_d;
            rdst_rdy_n_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hm_rx.sv
// tb_hm_rx: randomized CplD streams against a DW-stream reference model with a write scoreboard.
// Latency: expected writes are queued as beats are issued and matched when hm_data_we appears.
// Backpressure: source gaps are randomized through trn_rsrc_rdy_n; the DUT never stalls.
module tb_hm_rx;

    logic        trn_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        rx_start;
    logic        rx_end, rx_error, timeout;
    logic [63:0] trn_rd;
    logic        trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n;
    logic [6:0]  trn_rbar_hit_n;
    logic        trn_rdst_rdy_n, trn_rnp_ok_n;
    logic [63:0] hm_data;
    logic        hm_data_we;
    logic [8:0]  hm_data_addr;
    logic [15:0] stat_trn_cpt_rx;
    logic [7:0]  stat_trn_cpt_ign;
    logic [1:0]  stat_state;

    hm_rx dut (
        .trn_clk(trn_clk), .sys_rst(sys_rst), .rx_start(rx_start),
        .rx_end(rx_end), .rx_error(rx_error), .timeout(timeout),
        .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rerrfwd_n(trn_rerrfwd_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rnp_ok_n(trn_rnp_ok_n),
        .hm_data(hm_data), .hm_data_we(hm_data_we), .hm_data_addr(hm_data_addr),
        .stat_trn_cpt_rx(stat_trn_cpt_rx), .stat_trn_cpt_ign(stat_trn_cpt_ign), .stat_state(stat_state)
    );

    always #5 trn_clk = ~trn_clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [63:0] data;
        logic        last;
    } wr_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr = 0, n_end = 0, n_err = 0, n_tmo = 0;
    int b_wr = 0, b_end = 0, b_err = 0, b_tmo = 0;
    int gap_pct = 0;
    bit rand_data = 0;
    logic [31:0] dw_next = 32'd0;

    // Reference model: the request's payload as a flat DW stream cut into qword pairs.
    wr_t         exp_q[$];
    logic [31:0] m_pend[$];
    bit          m_armed = 0;
    int          m_qw = 0, m_rx = 0, m_ign = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic m_dw(input logic [31:0] d);
        wr_t w;
        if (!m_armed) return;
        m_pend.push_back(d);
        if (m_pend.size() == 2) begin
            w.addr = m_qw[8:0];
            w.data = {m_pend[0], m_pend[1]};
            w.last = (m_qw == 511);
            exp_q.push_back(w);
            m_pend.delete();
            m_qw++;
            if (m_qw == 512) m_armed = 0;
        end
    endtask

    function automatic logic [31:0] next_dw();
        logic [31:0] v;
        v = rand_data ? $urandom : dw_next;
        dw_next = dw_next + 32'd1;
        return v;
    endfunction

    // Scoreboard monitor: every write must match the oldest expected qword.
    always @(negedge trn_clk) begin
        if (!sys_rst) begin
            if (rx_error) n_err++;
            if (timeout)  n_tmo++;
            if (rx_end)   n_end++;
            if (hm_data_we) begin
                wr_t w;
                n_wr++;
                chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 64'(hm_data_addr), 64'(w.addr));
                    chk("wr_data", hm_data, w.data);
                    chk("wr_end",  64'(rx_end), 64'(w.last));
                end
            end else if (rx_end) begin
                chk("end_without_we", 64'(hm_data_we), 64'd1);
            end
        end
    end

    task automatic idle_inputs();
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rerrfwd_n  = 1'b1;
        trn_rsof_n     = 1'($urandom_range(0, 1));
        trn_reof_n     = 1'($urandom_range(0, 1));
        trn_rrem_n     = 1'($urandom_range(0, 1));
        trn_rd         = {$urandom, $urandom};
    endtask

    task automatic beat(input logic [63:0] d, input logic sof, input logic eof, input logic rrem_n);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            idle_inputs();
            @(posedge trn_clk); #1;
        end
        trn_rd         = d;
        trn_rsof_n     = ~sof;
        trn_reof_n     = ~eof;
        trn_rrem_n     = rrem_n;
        trn_rsrc_rdy_n = 1'b0;
        trn_rsrc_dsc_n = 1'b1;
        trn_rerrfwd_n  = 1'b1;
        @(posedge trn_clk); #1;
        idle_inputs();
    endtask

    task automatic arm();
        rx_start = 1'b1;
        @(posedge trn_clk); #1;
        rx_start = 1'b0;
        m_armed = 1;
        m_pend.delete();
        m_qw = 0;
    endtask

    task automatic send_cpld(input int len, input logic [2:0] st, input logic [7:0] tag,
                             input int max_beats, input bit chk_err);
        logic [31:0] d0, d1, d2, p, a, b;
        bit match;
        int rem, nb;
        d0 = {8'h4A, 14'h0, len[9:0]};
        d1 = {16'h0100, st, 1'b0, 12'(len * 4)};
        d2 = {16'h1800, tag, 8'h00};
        match = m_armed && (tag == 8'h38);
        if (m_armed && tag != 8'h38) m_ign++;
        beat({d0, d1}, 1'b1, 1'b0, 1'b1);
        p = (tag == 8'h38) ? next_dw() : $urandom;
        beat({d2, p}, 1'b0, len == 1, 1'b1);
        if (match) begin
            if (st != 3'd0) m_armed = 0;
            else begin m_rx++; m_dw(p); end
        end
        if (chk_err) chk("err_after_h1", 64'(rx_error), 64'd1);
        rem = len - 1;
        nb  = 2;
        while (rem > 0 && nb < max_beats) begin
            a = (tag == 8'h38) ? next_dw() : $urandom;
            b = (rem >= 2 && tag == 8'h38) ? next_dw() : $urandom;
            beat({a, b}, 1'b0, rem <= 2, rem >= 2);
            if (match && st == 3'd0) begin
                m_dw(a);
                if (rem >= 2) m_dw(b);
            end
            rem = rem - 2;
            nb++;
        end
    endtask

    task automatic send_mwr();
        if (m_armed) m_ign++;
        beat({8'h40, 14'h0, 10'd4, 32'h0000_000f}, 1'b1, 1'b0, 1'b1);
        beat({32'hdead_0000, $urandom}, 1'b0, 1'b0, 1'b1);
        beat({$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
        beat({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_hm_data"},   hm_data, 64'd0);
        chk({nm, "_we"},        64'(hm_data_we), 64'd0);
        chk({nm, "_addr"},      64'(hm_data_addr), 64'd0);
        chk({nm, "_end_err_to"}, 64'({rx_end, rx_error, timeout}), 64'd0);
        chk({nm, "_stats"},     64'({stat_trn_cpt_rx, stat_trn_cpt_ign, stat_state}), 64'd0);
        chk({nm, "_rdst_rdy_n"}, 64'(trn_rdst_rdy_n), 64'd1);
    endtask

    task automatic scn_check(input string nm, input int e_wr, input int e_end, input int e_err, input int e_tmo);
        repeat (4) @(posedge trn_clk);
        #1;
        chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_writes"},   64'(n_wr - b_wr), 64'(e_wr));
        chk({nm, "_rx_end"},   64'(n_end - b_end), 64'(e_end));
        chk({nm, "_rx_error"}, 64'(n_err - b_err), 64'(e_err));
        chk({nm, "_timeout"},  64'(n_tmo - b_tmo), 64'(e_tmo));
        chk({nm, "_cpt_rx"},   64'(stat_trn_cpt_rx), 64'(m_rx));
        chk({nm, "_cpt_ign"},  64'(stat_trn_cpt_ign), 64'(m_ign));
        chk({nm, "_state"},    64'(stat_state), 64'd0);
        b_wr = n_wr; b_end = n_end; b_err = n_err; b_tmo = n_tmo;
    endtask

    task automatic stream_8x128(input bit with_junk);
        for (int i = 0; i < 8; i++) begin
            send_cpld(128, 3'd0, 8'h38, 1 << 20, 1'b0);
            if (with_junk && i == 1) send_cpld(4, 3'd0, 8'h39, 1 << 20, 1'b0);
            if (with_junk && i == 5) send_mwr();
        end
    endtask

    initial begin
        int total, l, cnt;
        rx_start = 1'b0;
        trn_rbar_hit_n = 7'h7f;
        idle_inputs();
        #1 sys_rst = 1'b1;
        #2;
        chk_reset("por");
        @(posedge trn_clk); @(posedge trn_clk); #1;
        sys_rst = 1'b0;
        @(posedge trn_clk); #1;
        chk("rdst_rdy_after_rst", 64'(trn_rdst_rdy_n), 64'd0);
        chk("rnp_ok_n",           64'(trn_rnp_ok_n), 64'd0);

        // Baseline stream, DW i = i, no gaps.
        gap_pct = 0; rand_data = 0; dw_next = 32'd0;
        arm();
        stream_8x128(1'b0);
        scn_check("s1", 512, 1, 0, 0);

        // Same stream with a foreign-tag CplD and a MWr interleaved.
        dw_next = 32'd0;
        arm();
        stream_8x128(1'b1);
        scn_check("s2", 512, 1, 0, 0);

        // Bad completion status on the first CplD.
        dw_next = 32'd0;
        arm();
        send_cpld(128, 3'b001, 8'h38, 1 << 20, 1'b1);
        for (int i = 1; i < 8; i++) send_cpld(128, 3'd0, 8'h38, 1 << 20, 1'b0);
        scn_check("s3", 0, 0, 1, 0);

        // Baseline stream with 50% source gaps.
        gap_pct = 50; dw_next = 32'd0;
        arm();
        stream_8x128(1'b0);
        scn_check("s4", 512, 1, 0, 0);

        // Random CplD sizes (odd and even) with random payload.
        gap_pct = 30; rand_data = 1;
        arm();
        total = 0;
        while (total < 1024) begin
            l = $urandom_range(1, 200);
            if (l > 1024 - total) l = 1024 - total;
            send_cpld(l, 3'd0, 8'h38, 1 << 20, 1'b0);
            total += l;
        end
        scn_check("s4b", 512, 1, 0, 0);

        // Armed with no traffic.
        arm();
        cnt = 0;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge trn_clk); #1;
            if (timeout) begin cnt = i; break; end
        end
        chk("timeout_cycles", 64'(cnt), 64'd65536);
        m_armed = 0;
        scn_check("s5", 0, 0, 0, 1);

        // Reset in the middle of DATA, then a fresh stream.
        gap_pct = 0; rand_data = 1;
        arm();
        send_cpld(128, 3'd0, 8'h38, 1 << 20, 1'b0);
        send_cpld(128, 3'd0, 8'h38, 12, 1'b0);
        #2 sys_rst = 1'b1;
        exp_q.delete(); m_pend.delete();
        m_armed = 0; m_qw = 0; m_rx = 0; m_ign = 0;
        #1;
        chk_reset("mid_rst");
        @(posedge trn_clk); @(posedge trn_clk); #1;
        sys_rst = 1'b0;
        b_wr = n_wr; b_end = n_end; b_err = n_err; b_tmo = n_tmo;
        for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        chk("post_rst_state", 64'(stat_state), 64'd0);
        gap_pct = 20;
        arm();
        stream_8x128(1'b0);
        scn_check("s6", 512, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
